// File: rtl/pcie_msg_transmitter.sv
// pcie_msg_transmitter
//   Accepts one message command. The command gives a TLP header, a tag and the
//   location of the payload in local SRAM. The block reads the payload, splits
//   it into fragments and sends each fragment as one AXI INCR write burst.
//   Beat 0 of every burst is a fragment header:
//     {FragType[1:0], PKT_SN[1:0], MSG_TAG[3:0], TLP[119:0]}
//   Payload beats follow the header.
//   Only one burst is outstanding at a time, and AW and W are strictly
//   sequential.
//
//   Build option: PCIE_MSG_TX_BRESP_ABORT_EN
//     Defined:   a non-OKAY bresp skips all remaining fragments.
//     Undefined: every fragment is sent, and err still reports the bad bresp.
//
// Ports
//   clk, rst             clock, async active-high reset
//   cmd_*                command request; cmd_ready is high only in IDLE
//   sram_ren/raddr/rdata payload read port; rdata arrives the cycle after ren
//   axi_aw*/axi_w*/axi_b* AXI write master
//   done/err             one-cycle completion pulse with error status
//   busy                 high whenever not IDLE
module pcie_msg_transmitter #(
  parameter int MAX_FRAG_PAYLOAD = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [119:0] cmd_tlp,
  input  logic [3:0]   cmd_tag,
  input  logic [9:0]   cmd_sram_addr,
  input  logic [11:0]  cmd_payload_beats,
  input  logic [63:0]  cmd_axi_addr,
  output logic         sram_ren,
  output logic [9:0]   sram_raddr,
  input  logic [255:0] sram_rdata,
  output logic         axi_awvalid,
  input  logic         axi_awready,
  output logic [63:0]  axi_awaddr,
  output logic [11:0]  axi_awlen,
  output logic [2:0]   axi_awsize,
  output logic [1:0]   axi_awburst,
  output logic         axi_wvalid,
  input  logic         axi_wready,
  output logic [255:0] axi_wdata,
  output logic [31:0]  axi_wstrb,
  output logic         axi_wlast,
  input  logic         axi_bvalid,
  input  logic [1:0]   axi_bresp,
  output logic         axi_bready,
  output logic         done,
  output logic         err,
  output logic         busy
);

  localparam logic [11:0] MAX = 12'(MAX_FRAG_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_WHDR, S_RD, S_LAT, S_WDAT, S_BR, S_DONE
  } state_t;

  state_t state, nxt;

  logic         out_en;      // holds cmd_ready low until the first edge after reset
  logic [119:0] tlp_q;
  logic [3:0]   tag_q;
  logic [63:0]  axi_addr_q;
  logic [9:0]   addr_q;      // next SRAM address; wraps modulo 1024
  logic [11:0]  rem_q;       // payload beats not yet read, over the whole message
  logic [11:0]  frag_len_q;  // payload beats in the current fragment
  logic [11:0]  frag_cnt_q;  // payload beats still to read in the current fragment
  logic [1:0]   sn_q;
  logic         first_q, last_q, err_q;
  logic [255:0] wdata_q;
  logic         wlast_q;

  logic         accept, abort;
  logic [1:0]   frag_type;

  assign accept = cmd_valid & cmd_ready;

`ifdef PCIE_MSG_TX_BRESP_ABORT_EN
  assign abort = (axi_bresp != 2'b00);
`else
  assign abort = 1'b0;
`endif

  // S=10, M=00, L=01, SG=11 (a single fragment is both first and last).
  assign frag_type = {first_q, last_q};

  function automatic logic [11:0] clip(input logic [11:0] n);
    return (n > MAX) ? MAX : n;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (accept) nxt = (cmd_tag == 4'hF) ? S_DONE : S_AW;
      S_AW:   if (axi_awready) nxt = S_WHDR;
      S_WHDR: if (axi_wready) nxt = (frag_cnt_q != 12'd0) ? S_RD : S_BR;
      S_RD:   nxt = S_LAT;
      S_LAT:  nxt = S_WDAT;
      S_WDAT: if (axi_wready) nxt = (frag_cnt_q != 12'd0) ? S_RD : S_BR;
      S_BR:   if (axi_bvalid) nxt = (last_q || abort) ? S_DONE : S_AW;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready   = (state == S_IDLE) & out_en;
    busy        = (state != S_IDLE);
    axi_awvalid = (state == S_AW);
    axi_wvalid  = (state == S_WHDR) || (state == S_WDAT);
    sram_ren    = (state == S_RD);
    axi_bready  = (state == S_BR);
    done        = (state == S_DONE);
    err         = (state == S_DONE) & err_q;
  end

  assign sram_raddr  = addr_q;
  assign axi_awaddr  = axi_addr_q;
  assign axi_awlen   = frag_len_q;
  assign axi_awsize  = 3'b101;
  assign axi_awburst = 2'b01;
  assign axi_wstrb   = '1;
  assign axi_wdata   = wdata_q;
  assign axi_wlast   = wlast_q & axi_wvalid;

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_en     <= 1'b0;
      tlp_q      <= '0;
      tag_q      <= '0;
      axi_addr_q <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      frag_len_q <= '0;
      frag_cnt_q <= '0;
      sn_q       <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      wlast_q    <= 1'b0;
    end else begin
      out_en <= 1'b1;
      case (state)
        S_IDLE: if (accept) begin
          tlp_q      <= cmd_tlp;
          tag_q      <= cmd_tag;
          axi_addr_q <= cmd_axi_addr;
          addr_q     <= cmd_sram_addr;
          rem_q      <= cmd_payload_beats;
          frag_len_q <= clip(cmd_payload_beats);
          frag_cnt_q <= clip(cmd_payload_beats);
          sn_q       <= 2'd0;
          first_q    <= 1'b1;
          last_q     <= (cmd_payload_beats <= MAX);
          err_q      <= (cmd_tag == 4'hF);
        end
        // Load the header beat here so that it is stable for the whole WHDR state.
        S_AW: if (axi_awready) begin
          wdata_q <= {128'd0, frag_type, sn_q, tag_q, tlp_q};
          wlast_q <= (frag_len_q == 12'd0);
        end
        S_LAT: begin
          wdata_q    <= sram_rdata;
          wlast_q    <= (frag_cnt_q == 12'd1);
          frag_cnt_q <= frag_cnt_q - 12'd1;
          rem_q      <= rem_q - 12'd1;
          addr_q     <= addr_q + 10'd1;
        end
        S_BR: if (axi_bvalid) begin
          if (axi_bresp != 2'b00) err_q <= 1'b1;
          if (!(last_q || abort)) begin
            sn_q       <= sn_q + 2'd1;
            first_q    <= 1'b0;
            frag_len_q <= clip(rem_q);
            frag_cnt_q <= clip(rem_q);
            last_q     <= (rem_q <= MAX);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_msg_transmitter.sv
module tb_pcie_msg_transmitter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [119:0] cmd_tlp = '0;
  logic [3:0]   cmd_tag = '0;
  logic [9:0]   cmd_sram_addr = '0;
  logic [11:0]  cmd_payload_beats = '0;
  logic [63:0]  cmd_axi_addr = '0;
  logic         sram_ren;
  logic [9:0]   sram_raddr;
  logic [255:0] sram_rdata = '0;
  logic         axi_awvalid, axi_awready = 1'b0;
  logic [63:0]  axi_awaddr;
  logic [11:0]  axi_awlen;
  logic [2:0]   axi_awsize;
  logic [1:0]   axi_awburst;
  logic         axi_wvalid, axi_wready = 1'b0;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic         axi_wlast;
  logic         axi_bvalid = 1'b0;
  logic [1:0]   axi_bresp = 2'b00;
  logic         axi_bready;
  logic         done, err, busy;

  pcie_msg_transmitter #(.MAX_FRAG_PAYLOAD(15)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tlp(cmd_tlp),
    .cmd_tag(cmd_tag), .cmd_sram_addr(cmd_sram_addr),
    .cmd_payload_beats(cmd_payload_beats), .cmd_axi_addr(cmd_axi_addr),
    .sram_ren(sram_ren), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Captured traffic
  int           awl_q[$];
  logic [63:0]  awa_q[$];
  logic [255:0] wd_q[$];
  bit           wl_q[$];
  int           b_cnt = 0;
  bit           done_seen = 0;
  bit           done_err = 0;
  int           done_cnt = 0;
  bit           proto_bad = 0;
  bit           bad_first = 0;

  bit           aw_pend = 0, w_pend = 0;
  logic [63:0]  aw_addr_h;
  logic [11:0]  aw_len_h;
  logic [255:0] w_data_h;
  logic         w_last_h;

  // Payload pattern stored at each SRAM address.
  function automatic logic [255:0] pat(input logic [9:0] a);
    return {16{6'h2B, a}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SRAM model: one-cycle read latency.
  always @(posedge clk) if (sram_ren) sram_rdata <= pat(sram_raddr);

  // Random ready/response stalls. At each negedge this process first sets the
  // inputs, then records the handshakes that the coming posedge will complete.
  initial forever begin
    @(negedge clk);
    axi_awready = ($urandom_range(0, 3) != 0);
    axi_wready  = ($urandom_range(0, 3) != 0);
    if (axi_bready) begin
      axi_bvalid = ($urandom_range(0, 2) != 0);
      axi_bresp  = (bad_first && b_cnt == 0) ? 2'b10 : 2'b00;
    end else begin
      axi_bvalid = 1'b0;
      axi_bresp  = 2'b00;
    end
    if (rst) begin
      aw_pend = 0;
      w_pend  = 0;
    end else begin
      if (axi_awvalid && axi_wvalid) proto_bad = 1;
      if (aw_pend && axi_awvalid && (axi_awaddr !== aw_addr_h || axi_awlen !== aw_len_h))
        proto_bad = 1;
      if (w_pend && axi_wvalid && (axi_wdata !== w_data_h || axi_wlast !== w_last_h))
        proto_bad = 1;
      if (axi_awvalid && axi_awready) begin
        awl_q.push_back(int'(axi_awlen));
        awa_q.push_back(axi_awaddr);
      end
      if (axi_wvalid && axi_wready) begin
        wd_q.push_back(axi_wdata);
        wl_q.push_back(axi_wlast);
      end
      if (axi_bvalid && axi_bready) b_cnt++;
      if (done) begin
        done_seen = 1;
        done_err  = err;
        done_cnt++;
      end
      aw_pend   = axi_awvalid && !axi_awready;
      aw_addr_h = axi_awaddr;
      aw_len_h  = axi_awlen;
      w_pend    = axi_wvalid && !axi_wready;
      w_data_h  = axi_wdata;
      w_last_h  = axi_wlast;
    end
  end

  // Issue one command, wait for done, then check every captured burst.
  task automatic run_cmd(input int p, input int tag, input int addr,
                         input int nb_exp, input bit err_exp, input bit bad1,
                         input string name);
    int n_total, bi, pi, len, tot;
    logic [1:0]   ft;
    logic [119:0] tlp;
    logic [63:0]  aa;
    tlp = {8'hA5, 112'h0123456789ABCDEFFEDCBA987654} ^ 120'(p);
    aa  = 64'hDEAD_0000_0000_1000 + 64'(p);
    awl_q.delete(); awa_q.delete(); wd_q.delete(); wl_q.delete();
    b_cnt = 0; done_seen = 0; done_cnt = 0; proto_bad = 0; bad_first = bad1;
    @(negedge clk);
    cmd_tlp = tlp; cmd_tag = 4'(tag); cmd_sram_addr = 10'(addr);
    cmd_payload_beats = 12'(p); cmd_axi_addr = aa; cmd_valid = 1'b1;
    while (!cmd_ready) @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({name, ":busy"}, busy, 1'b1);
    if (tag != 15) chk({name, ":aw_latency"}, axi_awvalid, 1'b1);
    for (int c = 0; c < 5000 && !done_seen; c++) @(posedge clk);
    chk({name, ":done_seen"}, done_seen, 1'b1);
    @(negedge clk);
    chk({name, ":done_err"}, done_err, err_exp);
    chk({name, ":done_once"}, done_cnt, 1);
    chk({name, ":protocol"}, proto_bad, 1'b0);
    chk({name, ":aw_count"}, awl_q.size(), nb_exp);
    n_total = (p <= 15) ? 1 : (p + 14) / 15;
    tot = 0;
    for (int f = 0; f < nb_exp; f++) tot += ((f < n_total - 1) ? 15 : p - (n_total - 1) * 15) + 1;
    chk({name, ":w_count"}, wd_q.size(), tot);
    if (awl_q.size() == nb_exp && wd_q.size() == tot) begin
      bi = 0; pi = 0;
      for (int f = 0; f < nb_exp; f++) begin
        len = (f < n_total - 1) ? 15 : p - (n_total - 1) * 15;
        if (n_total == 1)           ft = 2'b11;
        else if (f == 0)            ft = 2'b10;
        else if (f == n_total - 1)  ft = 2'b01;
        else                        ft = 2'b00;
        chk($sformatf("%s:awlen%0d", name, f), awl_q[f], len);
        chk($sformatf("%s:awaddr%0d", name, f), awa_q[f], aa);
        chk($sformatf("%s:hdr%0d", name, f), wd_q[bi],
            {128'd0, ft, 2'(f), 4'(tag), tlp});
        chk($sformatf("%s:hdr_last%0d", name, f), wl_q[bi], len == 0);
        bi++;
        for (int k = 0; k < len; k++) begin
          chk($sformatf("%s:data%0d_%0d", name, f, k), wd_q[bi], pat(10'((addr + pi) % 1024)));
          chk($sformatf("%s:last%0d_%0d", name, f, k), wl_q[bi], k == len - 1);
          bi++; pi++;
        end
      end
    end
    bad_first = 0;
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst:cmd_ready", cmd_ready, 1'b0);
    chk("rst:awvalid", axi_awvalid, 1'b0);
    chk("rst:wvalid", axi_wvalid, 1'b0);
    chk("rst:sram_ren", sram_ren, 1'b0);
    chk("rst:bready", axi_bready, 1'b0);
    chk("rst:done", done, 1'b0);
    chk("rst:busy", busy, 1'b0);
    chk("rst:awsize", axi_awsize, 3'b101);
    chk("rst:awburst", axi_awburst, 2'b01);
    chk("rst:wstrb", axi_wstrb, 32'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst:ready_low_after_release", cmd_ready, 1'b0);
    @(negedge clk);
    chk("rst:ready_rises", cmd_ready, 1'b1);

    run_cmd(3,  5,  16,   1, 1'b0, 1'b0, "p3");
    run_cmd(40, 2,  256,  3, 1'b0, 1'b0, "p40");
    run_cmd(75, 7,  1020, 5, 1'b0, 1'b0, "p75_wrap");
    run_cmd(0,  1,  5,    1, 1'b0, 1'b0, "p0");
    run_cmd(15, 14, 100,  1, 1'b0, 1'b0, "p15");
    run_cmd(8,  15, 0,    0, 1'b1, 1'b0, "tag15");
`ifdef PCIE_MSG_TX_BRESP_ABORT_EN
    run_cmd(40, 3,  512,  1, 1'b1, 1'b1, "p40_bresp");
`else
    run_cmd(40, 3,  512,  3, 1'b1, 1'b1, "p40_bresp");
`endif

    // Asynchronous reset in the middle of a message
    @(negedge clk);
    cmd_tlp = '0; cmd_tag = 4'd4; cmd_sram_addr = 10'd0;
    cmd_payload_beats = 12'd40; cmd_axi_addr = 64'h0; cmd_valid = 1'b1;
    while (!cmd_ready) @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst:busy", busy, 1'b0);
    chk("midrst:awvalid", axi_awvalid, 1'b0);
    chk("midrst:wvalid", axi_wvalid, 1'b0);
    chk("midrst:sram_ren", sram_ren, 1'b0);
    chk("midrst:bready", axi_bready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_cmd(2, 9, 700, 1, 1'b0, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
